poly_eval_seq: RTL and testbench

- Sequential, parametrised multivariate polynomial evaluator: result = sum over i of coef_i * prod over v of x_v^exp_i,v, reduced mod 2^OUT_W.
- Term table is runtime-programmable; one shared OUT_W x OUT_W multiplier is reused across cycles instead of a flat combinational expression.
- Successor of the team's fixed-coefficient combinational polynomial blocks, in the same datapath slot, with valid/ready handshakes on both sides.

---
 rtl/poly_eval_pkg.sv | 31 +++
 rtl/poly_term_table.sv | 38 +++
 rtl/poly_eval_seq.sv | 167 ++++++++++++++++
 tb/tb_poly_eval_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/poly_eval_pkg.sv
// Shared types and helpers for the sequential polynomial evaluator.
// Contents:
//   state_t    - evaluator FSM states
//   *_DEF      - default parameter values for poly_eval_seq
//   get_field  - extracts field v (width w) from a packed vector of up to 64 bits
package poly_eval_pkg;

  localparam int unsigned NVARS_DEF     = 3;
  localparam int unsigned IN_W_DEF      = 8;
  localparam int unsigned OUT_W_DEF     = 24;
  localparam int unsigned COEF_W_DEF    = 24;
  localparam int unsigned EXP_W_DEF     = 3;
  localparam int unsigned MAX_TERMS_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    TERM,
    MUL,
    ACC,
    DONE
  } state_t;

  function automatic logic [31:0] get_field(input logic [63:0] vec,
                                            input int unsigned v,
                                            input int unsigned w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return 32'((vec >> (v * w)) & mask);
  endfunction

endpackage

// File: rtl/poly_term_table.sv
// Term table for poly_eval_seq: MAX_TERMS entries of {coefficient, exponents}.
// Synchronous write port, asynchronous read port, contents not reset.
// Ports:
//   clk          clock
//   we           write strobe (already gated to IDLE by the parent)
//   waddr        write index
//   wcoef/wexp   entry written
//   raddr        read index
//   rcoef/rexp   entry at raddr (combinational)
module poly_term_table #(
  parameter int unsigned MAX_TERMS = 32,
  parameter int unsigned COEF_W    = 24,
  parameter int unsigned EXP_BITS  = 9
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(MAX_TERMS)-1:0] waddr,
  input  logic [COEF_W-1:0]            wcoef,
  input  logic [EXP_BITS-1:0]          wexp,
  input  logic [$clog2(MAX_TERMS)-1:0] raddr,
  output logic [COEF_W-1:0]            rcoef,
  output logic [EXP_BITS-1:0]          rexp
);

  logic [COEF_W-1:0]   coef_mem [MAX_TERMS];
  logic [EXP_BITS-1:0] exp_mem  [MAX_TERMS];

  always_ff @(posedge clk) begin
    if (we) begin
      coef_mem[waddr] <= wcoef;
      exp_mem[waddr]  <= wexp;
    end
  end

  assign rcoef = coef_mem[raddr];
  assign rexp  = exp_mem[raddr];

endmodule

// File: rtl/poly_eval_seq.sv
// Sequential multivariate polynomial evaluator:
//   result = sum_i coef_i * prod_v x_v^exp_i,v  (mod 2^OUT_W)
// using one shared OUT_W x OUT_W multiplier over several cycles.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_we/addr/coef/exp  term table write (honoured only in IDLE)
//   cfg_nterms            active term count, sampled at acceptance, clamped to MAX_TERMS
//   in_valid/in_ready     operand handshake, in_vars packed v at [v*IN_W +: IN_W]
//   out_valid/out_ready   result handshake, out_result held while waiting
//   busy                  high outside IDLE
// Optional (macro POLY_EVAL_STAT_EN):
//   stat_cycles           acceptance-to-valid cycles of the last result, saturating
//   stat_count            completed results, wrapping
module poly_eval_seq
  import poly_eval_pkg::*;
#(
  parameter int unsigned NVARS     = NVARS_DEF,
  parameter int unsigned IN_W      = IN_W_DEF,
  parameter int unsigned OUT_W     = OUT_W_DEF,
  parameter int unsigned COEF_W    = COEF_W_DEF,
  parameter int unsigned EXP_W     = EXP_W_DEF,
  parameter int unsigned MAX_TERMS = MAX_TERMS_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [$clog2(MAX_TERMS)-1:0] cfg_addr,
  input  logic [COEF_W-1:0]            cfg_coef,
  input  logic [NVARS*EXP_W-1:0]       cfg_exp,
  input  logic [$clog2(MAX_TERMS):0]   cfg_nterms,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NVARS*IN_W-1:0]        in_vars,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_W-1:0]             out_result,
  output logic                         busy
`ifdef POLY_EVAL_STAT_EN
  ,
  output logic [15:0]                  stat_cycles,
  output logic [15:0]                  stat_count
`endif
);

  localparam int unsigned AW = $clog2(MAX_TERMS);
  localparam int unsigned NW = AW + 1;
  localparam int unsigned EB = NVARS * EXP_W;

  state_t                  state_q, state_d;
  logic [NVARS*IN_W-1:0]   vars_q;
  logic [NW-1:0]           nterms_q;
  logic [AW-1:0]           idx_q;
  logic [OUT_W-1:0]        acc_q, prod_q, mul_res;
  logic [EB-1:0]           cnt_q, cnt_dec;
  logic [COEF_W-1:0]       rd_coef;
  logic [EB-1:0]           rd_exp;
  logic [IN_W-1:0]         x_sel;
  int unsigned             sel_v;
  logic                    accept, tbl_we, last_term;

  assign accept    = in_valid && (state_q == IDLE);
  assign tbl_we    = cfg_we && (state_q == IDLE);
  assign last_term = ({1'b0, idx_q} + NW'(1)) >= nterms_q;

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = acc_q;

  poly_term_table #(
    .MAX_TERMS (MAX_TERMS),
    .COEF_W    (COEF_W),
    .EXP_BITS  (EB)
  ) u_table (
    .clk   (clk),
    .we    (tbl_we),
    .waddr (cfg_addr),
    .wcoef (cfg_coef),
    .wexp  (cfg_exp),
    .raddr (idx_q),
    .rcoef (rd_coef),
    .rexp  (rd_exp)
  );

  // Lowest variable with a nonzero remaining exponent feeds the multiplier.
  // The selected field is nonzero, so subtracting its unit never borrows
  // into a neighbouring field.
  always_comb begin
    sel_v = 0;
    for (int unsigned v = NVARS; v > 0; v--) begin
      if (get_field(64'(cnt_q), v - 1, EXP_W) != '0) sel_v = v - 1;
    end
    x_sel   = IN_W'(get_field(64'(vars_q), sel_v, IN_W));
    mul_res = prod_q * OUT_W'(x_sel);
    cnt_dec = cnt_q - (EB'(1) << (sel_v * EXP_W));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (cfg_nterms == '0) ? DONE : TERM;
      TERM:    state_d = (rd_exp == '0) ? ACC : MUL;
      MUL:     state_d = (cnt_dec == '0) ? ACC : MUL;
      ACC:     state_d = last_term ? DONE : TERM;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vars_q   <= '0;
      nterms_q <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            vars_q   <= in_vars;
            nterms_q <= (cfg_nterms > NW'(MAX_TERMS)) ? NW'(MAX_TERMS) : cfg_nterms;
            idx_q    <= '0;
            acc_q    <= '0;
          end
        end
        TERM: begin
          prod_q <= OUT_W'($signed(rd_coef));
          cnt_q  <= rd_exp;
        end
        MUL: begin
          prod_q <= mul_res;
          cnt_q  <= cnt_dec;
        end
        ACC: begin
          acc_q <= acc_q + prod_q;
          if (!last_term) idx_q <= idx_q + AW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef POLY_EVAL_STAT_EN
  // run_q holds the number of edges since acceptance, so on the edge that
  // enters DONE from ACC it equals the latency of this result.
  logic [15:0] run_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= '0;
      stat_cycles <= '0;
      stat_count  <= '0;
    end else begin
      if (accept)             run_q <= 16'd1;
      else if (run_q != '1)   run_q <= run_q + 16'd1;
      if (state_d == DONE && state_q != DONE)
        stat_cycles <= (state_q == IDLE) ? 16'd1 : run_q;
      if (out_valid && out_ready) stat_count <= stat_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_poly_eval_seq.sv
// Directed bench for poly_eval_seq: a default-width instance and an
// OUT_W=16 / COEF_W=16 instance driven in lockstep from the same stimulus.
module tb_poly_eval_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [23:0] cfg_coef = '0;
  logic [8:0]  cfg_exp = '0;
  logic [5:0]  cfg_nterms = '0;
  logic        in_valid = 1'b0;
  logic [23:0] in_vars = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, busy;
  logic [23:0] out_result;
  logic        in_ready16, out_valid16, busy16;
  logic [15:0] out_result16;
`ifdef POLY_EVAL_STAT_EN
  logic [15:0] stat_cycles, stat_count, stat_cycles16, stat_count16;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  poly_eval_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_coef   (cfg_coef),
    .cfg_exp    (cfg_exp),
    .cfg_nterms (cfg_nterms),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vars    (in_vars),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
`ifdef POLY_EVAL_STAT_EN
    ,
    .stat_cycles (stat_cycles),
    .stat_count  (stat_count)
`endif
  );

  poly_eval_seq #(
    .OUT_W  (16),
    .COEF_W (16)
  ) dut16 (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_coef   (cfg_coef[15:0]),
    .cfg_exp    (cfg_exp),
    .cfg_nterms (cfg_nterms),
    .in_valid   (in_valid),
    .in_ready   (in_ready16),
    .in_vars    (in_vars),
    .out_valid  (out_valid16),
    .out_ready  (out_ready),
    .out_result (out_result16),
    .busy       (busy16)
`ifdef POLY_EVAL_STAT_EN
    ,
    .stat_cycles (stat_cycles16),
    .stat_count  (stat_count16)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic cfg_write(input logic [4:0] addr, input logic [23:0] coef, input logic [8:0] ex);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_coef = coef;
    cfg_exp  = ex;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Called only while the DUT is in IDLE, so the next edge accepts.
  task automatic start(input logic [23:0] vars, input logic [5:0] nterms);
    in_vars    = vars;
    cfg_nterms = nterms;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  task automatic wait_valid(input string tag, input logic [23:0] exp24,
                            input logic [15:0] exp16, input int exp_lat);
    int n = 0;
    while (!out_valid && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_valid"},   32'(out_valid),    32'd1);
    check({tag, "_valid16"}, 32'(out_valid16),  32'd1);
    check({tag, "_lat"},     32'(cyc - acc_cyc), 32'(exp_lat));
    check({tag, "_res"},     32'(out_result),   32'(exp24));
    check({tag, "_res16"},   32'(out_result16), 32'(exp16));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_vld_low"},  32'(out_valid),  32'd0);
    check({tag, "_rdy_high"}, 32'(in_ready),   32'd1);
    check({tag, "_rdy16"},    32'(in_ready16), 32'd1);
  endtask

  task automatic wait_done(input string tag, input logic [23:0] exp24,
                           input logic [15:0] exp16, input int exp_lat);
    wait_valid(tag, exp24, exp16, exp_lat);
    release_out(tag);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),     32'd1);
    check("rst_out_valid", 32'(out_valid),    32'd0);
    check("rst_result",    32'(out_result),   32'd0);
    check("rst_busy",      32'(busy),         32'd0);
    check("rst_result16",  32'(out_result16), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // coef 1, x0^1 * x2^1, vars (2,3,5): 10, latency 2+2
    cfg_write(5'd0, 24'd1, 9'b001_000_001);
    start(24'h050302, 6'd1);
    check("single_busy", 32'(busy), 32'd1);
    wait_done("single", 24'd10, 16'd10, 4);

    // x0^3 with x0=255: 16581375; 16-bit: 16581375 mod 65536 = 767
    cfg_write(5'd0, 24'd1, 9'b000_000_011);
    start(24'h0000FF, 6'd1);
    wait_done("wrap", 24'd16581375, 16'd767, 5);

    // coef -1, x1^1, x1=3: -3
    cfg_write(5'd0, 24'hFFFFFF, 9'b000_001_000);
    start(24'h000300, 6'd1);
    wait_done("neg", 24'hFFFFFD, 16'hFFFD, 3);

    // x0 + x1*x2^2 at (2,3,5) = 2 + 75 = 77, latency 3 + 5; table write mid-run ignored
    cfg_write(5'd0, 24'd1, 9'b000_000_001);
    cfg_write(5'd1, 24'd1, 9'b010_001_000);
    start(24'h050302, 6'd2);
    @(posedge clk); #1;
    cfg_write(5'd1, 24'd100, 9'd0);
    wait_valid("two", 24'd77, 16'd77, 8);
    release_out("two");
    start(24'h050302, 6'd2);
    wait_done("reread", 24'd77, 16'd77, 8);

    // Backpressure: result held, second input waits for the out handshake
    start(24'h050302, 6'd2);
    wait_valid("bp1", 24'd77, 16'd77, 8);
    in_vars  = 24'h010101;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_res",   32'(out_result), 32'd77);
      check("bp_hold_valid", 32'(out_valid),  32'd1);
      check("bp_hold_rdy",   32'(in_ready),   32'd0);
    end
    release_out("bp1");
    check("bp_not_yet", 32'(busy), 32'd0);
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    check("bp_accept", 32'(busy), 32'd1);
    wait_done("bp2", 24'd2, 16'd2, 8);

    // nterms = 0: result 0, valid right after the accepting edge
    start(24'h050302, 6'd0);
    wait_done("zero", 24'd0, 16'd0, 0);

    // nterms clamped to 32: 32 constant terms of 1, two cycles each
    for (int i = 0; i < 32; i++) cfg_write(5'(i), 24'd1, 9'd0);
    start(24'h050302, 6'd40);
    wait_done("clamp", 24'd32, 16'd32, 64);

    // Write and accept in the same cycle: evaluation sees the new entry
    cfg_we   = 1'b1;
    cfg_addr = 5'd0;
    cfg_coef = 24'd5;
    cfg_exp  = 9'd0;
    start(24'h050302, 6'd1);
    cfg_we = 1'b0;
    wait_done("wr_acc", 24'd5, 16'd5, 2);

    // Reset during MUL aborts; next run with the same table is correct
    cfg_write(5'd0, 24'd1, 9'b000_000_011);
    start(24'h000002, 6'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_valid",  32'(out_valid),    32'd0);
    check("abort_ready",  32'(in_ready),     32'd1);
    check("abort_busy",   32'(busy),         32'd0);
    check("abort_busy16", 32'(busy16),       32'd0);
    check("abort_result", 32'(out_result),   32'd0);
    @(posedge clk); #1;
    check("abort_hold", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start(24'h000002, 6'd1);
    wait_done("after_rst", 24'd8, 16'd8, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
